data_mem_port_arbiter: RTL and testbench
========================================

Name: data_mem_port_arbiter

Overview:
- Shares the single data-memory port 2 between the load functional unit and the store functional unit of the out-of-order OTTER.
- Accepts one request per requester through a req/gnt handshake and arbitrates round-robin.
- Sequences the memory access over a fixed latency, then returns a one-cycle response pulse carrying the requester's reservation-station tag.
- Response to the store unit is the mem_resp / mem_resp_valid pair that the store unit consumes to complete.

Parameters:
MEM_LATENCY, 1, cycles from the memory strobe cycle to the cycle read data/write completion is valid (range 1-7)
TAG_W, 4, width of the reservation-station tag carried through with a request

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
ld_req  in  1  load unit request, held until ld_gnt
ld_addr  in  32  load byte address
ld_type  in  3  [2]=unsigned, [1:0]=size (0 byte, 1 half, 2 word)
ld_tag  in  TAG_W  load destination tag
ld_gnt  out  1  request accepted this cycle
ld_resp_valid  out  1  one-cycle load response pulse
ld_resp_data  out  32  load data, valid with ld_resp_valid
ld_resp_tag  out  TAG_W  tag of completed load
ld_resp_err  out  1  misaligned load, no memory access made
st_req  in  1  store unit request, held until st_gnt
st_addr  in  32  store byte address
st_data  in  32  store data
st_type  in  3  same encoding as ld_type
st_tag  in  TAG_W  store tag
st_gnt  out  1  request accepted this cycle
mem_resp_valid  out  1  one-cycle store response pulse
mem_resp  out  1  1 = store done, 0 = misaligned, not written
st_resp_tag  out  TAG_W  tag of completed store
MEM_ADDR2  out  32  memory address
MEM_READ2  out  1  read strobe
MEM_WRITE  out  1  write strobe
MEM_WRITE_DATA  out  32  write data
MEM_SIGN  out  1  latched type[2]
MEM_SIZE  out  2  latched type[1:0]
MEM_DOUT2  in  32  memory read data

Behaviour:
- Reset (async, RST=1): state=IDLE; all outputs 0; last_grant=LOAD, so a store wins the first tie; latency counter=0; in-flight access abandoned, no response ever issued for it.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req, grant combinationally that cycle, exactly one gnt high.
  - Both requesting: grant the requester not equal to last_grant.
  - On the grant edge: latch addr/data/type/tag/owner; update last_grant.
  - Aligned request -> ACCESS. Misaligned (word with addr[1:0]!=0, half with addr[0]!=0) -> RESP with err=1.
  - Requester must drop req the cycle after gnt or it is treated as a new request.
- ACCESS:
  - MEM_ADDR2/MEM_SIGN/MEM_SIZE/MEM_WRITE_DATA driven from latches for the whole state; 0 outside ACCESS.
  - MEM_READ2 (load) or MEM_WRITE (store) high only in the first ACCESS cycle.
  - Counter runs 0..MEM_LATENCY-1; at MEM_LATENCY-1, capture MEM_DOUT2 for loads, go RESP.
  - ACCESS lasts exactly MEM_LATENCY cycles.
- RESP:
  - Exactly one of ld_resp_valid / mem_resp_valid pulses high for one cycle with tag and data/err; go IDLE.
  - No gnt in RESP.
  - Store: mem_resp=1 if aligned, else 0. Load: ld_resp_err = misaligned, ld_resp_data=0 on error.
- Latency: grant at cycle N; strobe N+1; response N+1+MEM_LATENCY. Misaligned: response N+1, no strobe.
- Throughput: one access per MEM_LATENCY+2 cycles.
- New req during ACCESS/RESP: held and not granted until IDLE; no starvation under continuous dual requests, grants alternate.
- Load data passes through unmodified; sign/size extension is done by memory.

Test Plan:
1. Reset then st_req alone, addr 0x100, data 0xDEADBEEF, type 3'b010, tag 5, MEM_LATENCY=1 -> st_gnt cycle 0; MEM_WRITE=1, MEM_ADDR2=0x100 cycle 1 only; mem_resp_valid=1, mem_resp=1, st_resp_tag=5 cycle 2.
2. ld_req and st_req same cycle after reset, held -> store granted first; load granted at first IDLE after store response; a further simultaneous pair grants load then store.
3. Load addr 0x200 word, memory returns 0x12345678, MEM_LATENCY=3 -> MEM_READ2 one cycle; ld_resp_valid 4 cycles after gnt, data 0x12345678.
4. Store word addr 0x102 -> no MEM_WRITE ever; mem_resp_valid=1 with mem_resp=0 one cycle after gnt. Load half addr 0x201 -> ld_resp_err=1.
5. Assert RST during ACCESS of a load -> all outputs 0 immediately; no ld_resp_valid afterwards; a new request after release is granted normally.
6. Continuous ld_req and st_req for 20 cycles, MEM_LATENCY=1 -> grants strictly alternate, one every 3 cycles, never two gnts in one cycle.

Source files
------------

// File: rtl/data_mem_port_arbiter.sv
// Round-robin arbiter sharing data-memory port 2 between the load and store units.
// Each granted request runs a fixed-latency access, then a one-cycle tagged response pulse.
module data_mem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int TAG_W       = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_type,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             ld_gnt,
    output logic             ld_resp_valid,
    output logic [31:0]      ld_resp_data,
    output logic [TAG_W-1:0] ld_resp_tag,
    output logic             ld_resp_err,
    input  logic             st_req,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       st_type,
    input  logic [TAG_W-1:0] st_tag,
    output logic             st_gnt,
    output logic             mem_resp_valid,
    output logic             mem_resp,
    output logic [TAG_W-1:0] st_resp_tag,
    output logic [31:0]      MEM_ADDR2,
    output logic             MEM_READ2,
    output logic             MEM_WRITE,
    output logic [31:0]      MEM_WRITE_DATA,
    output logic             MEM_SIGN,
    output logic [1:0]       MEM_SIZE,
    input  logic [31:0]      MEM_DOUT2
);

    localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             state_r;
    logic               last_st_r;
    logic               owner_st_r;
    logic [TAG_W-1:0]   tag_r;
    logic [2:0]         cnt_r;

    logic               grant_ld_s;
    logic               grant_st_s;
    logic [31:0]        sel_addr_s;
    logic [2:0]         sel_type_s;
    logic [TAG_W-1:0]   sel_tag_s;
    logic               sel_mis_s;

    function automatic logic misaligned(input logic [2:0] mtype, input logic [1:0] addr_lo);
        logic res;
        res = 1'b0;
        case (mtype[1:0])
            2'd1:    res = addr_lo[0];
            2'd2:    res = (addr_lo != 2'd0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Grant decision: only in IDLE, and on a tie the side that did not win last time
    always_comb begin
        grant_ld_s = 1'b0;
        grant_st_s = 1'b0;
        if (!RST && (state_r == S_IDLE)) begin
            if (ld_req && st_req) begin
                if (last_st_r) begin
                    grant_ld_s = 1'b1;
                end else begin
                    grant_st_s = 1'b1;
                end
            end else begin
                grant_ld_s = ld_req;
                grant_st_s = st_req;
            end
        end else begin
            grant_ld_s = 1'b0;
            grant_st_s = 1'b0;
        end
    end

    // Request fields of whichever side is being granted
    always_comb begin
        sel_addr_s = 32'd0;
        sel_type_s = 3'd0;
        sel_tag_s  = {TAG_W{1'b0}};
        if (grant_st_s) begin
            sel_addr_s = st_addr;
            sel_type_s = st_type;
            sel_tag_s  = st_tag;
        end else begin
            sel_addr_s = ld_addr;
            sel_type_s = ld_type;
            sel_tag_s  = ld_tag;
        end
        sel_mis_s = misaligned(sel_type_s, sel_addr_s[1:0]);
    end

    assign ld_gnt = grant_ld_s;
    assign st_gnt = grant_st_s;

    // Access sequencer; all memory and response outputs are registered here
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r        <= S_IDLE;
            last_st_r      <= 1'b0;
            owner_st_r     <= 1'b0;
            tag_r          <= {TAG_W{1'b0}};
            cnt_r          <= 3'd0;
            MEM_ADDR2      <= 32'd0;
            MEM_READ2      <= 1'b0;
            MEM_WRITE      <= 1'b0;
            MEM_WRITE_DATA <= 32'd0;
            MEM_SIGN       <= 1'b0;
            MEM_SIZE       <= 2'd0;
            ld_resp_valid  <= 1'b0;
            ld_resp_data   <= 32'd0;
            ld_resp_tag    <= {TAG_W{1'b0}};
            ld_resp_err    <= 1'b0;
            mem_resp_valid <= 1'b0;
            mem_resp       <= 1'b0;
            st_resp_tag    <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_ld_s || grant_st_s) begin
                        owner_st_r <= grant_st_s;
                        last_st_r  <= grant_st_s;
                        tag_r      <= sel_tag_s;
                        cnt_r      <= 3'd0;
                        if (sel_mis_s) begin
                            // Misaligned: skip the memory entirely and answer with an error
                            state_r <= S_RESP;
                            if (grant_st_s) begin
                                mem_resp_valid <= 1'b1;
                                mem_resp       <= 1'b0;
                                st_resp_tag    <= sel_tag_s;
                            end else begin
                                ld_resp_valid <= 1'b1;
                                ld_resp_err   <= 1'b1;
                                ld_resp_data  <= 32'd0;
                                ld_resp_tag   <= sel_tag_s;
                            end
                        end else begin
                            state_r        <= S_ACCESS;
                            MEM_ADDR2      <= sel_addr_s;
                            MEM_SIGN       <= sel_type_s[2];
                            MEM_SIZE       <= sel_type_s[1:0];
                            MEM_WRITE_DATA <= grant_st_s ? st_data : 32'd0;
                            MEM_READ2      <= grant_ld_s;
                            MEM_WRITE      <= grant_st_s;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    MEM_READ2 <= 1'b0;
                    MEM_WRITE <= 1'b0;
                    if (cnt_r == LAST_CNT) begin
                        state_r        <= S_RESP;
                        MEM_ADDR2      <= 32'd0;
                        MEM_WRITE_DATA <= 32'd0;
                        MEM_SIGN       <= 1'b0;
                        MEM_SIZE       <= 2'd0;
                        if (owner_st_r) begin
                            mem_resp_valid <= 1'b1;
                            mem_resp       <= 1'b1;
                            st_resp_tag    <= tag_r;
                        end else begin
                            ld_resp_valid <= 1'b1;
                            ld_resp_err   <= 1'b0;
                            ld_resp_data  <= MEM_DOUT2;
                            ld_resp_tag   <= tag_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                S_RESP: begin
                    state_r        <= S_IDLE;
                    ld_resp_valid  <= 1'b0;
                    ld_resp_data   <= 32'd0;
                    ld_resp_tag    <= {TAG_W{1'b0}};
                    ld_resp_err    <= 1'b0;
                    mem_resp_valid <= 1'b0;
                    mem_resp       <= 1'b0;
                    st_resp_tag    <= {TAG_W{1'b0}};
                end
                default: begin
                    state_r        <= S_IDLE;
                    MEM_ADDR2      <= 32'd0;
                    MEM_READ2      <= 1'b0;
                    MEM_WRITE      <= 1'b0;
                    MEM_WRITE_DATA <= 32'd0;
                    MEM_SIGN       <= 1'b0;
                    MEM_SIZE       <= 2'd0;
                    ld_resp_valid  <= 1'b0;
                    mem_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_port_arbiter.sv
// Directed cycle-exact bench: instance a uses MEM_LATENCY=1, instance b uses MEM_LATENCY=3.
module tb_data_mem_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        ld_req, st_req, ld_req_b, st_req_b;
    logic [31:0] ld_addr, st_addr, st_data, MEM_DOUT2;
    logic [2:0]  ld_type, st_type;
    logic [3:0]  ld_tag, st_tag;

    logic        a_ld_gnt, a_ld_resp_valid, a_ld_resp_err, a_st_gnt, a_mem_resp_valid, a_mem_resp;
    logic [31:0] a_ld_resp_data, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_ld_resp_tag, a_st_resp_tag;
    logic        a_mem_read, a_mem_write, a_mem_sign;
    logic [1:0]  a_mem_size;

    logic        b_ld_gnt, b_ld_resp_valid, b_ld_resp_err, b_st_gnt, b_mem_resp_valid, b_mem_resp;
    logic [31:0] b_ld_resp_data, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_ld_resp_tag, b_st_resp_tag;
    logic        b_mem_read, b_mem_write, b_mem_sign;
    logic [1:0]  b_mem_size;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_port_arbiter #(.MEM_LATENCY(1), .TAG_W(4)) u_dut_a (
        .CLK(CLK), .RST(RST),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_tag(ld_tag),
        .ld_gnt(a_ld_gnt), .ld_resp_valid(a_ld_resp_valid), .ld_resp_data(a_ld_resp_data),
        .ld_resp_tag(a_ld_resp_tag), .ld_resp_err(a_ld_resp_err),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .st_tag(st_tag),
        .st_gnt(a_st_gnt), .mem_resp_valid(a_mem_resp_valid), .mem_resp(a_mem_resp),
        .st_resp_tag(a_st_resp_tag),
        .MEM_ADDR2(a_mem_addr), .MEM_READ2(a_mem_read), .MEM_WRITE(a_mem_write),
        .MEM_WRITE_DATA(a_mem_wdata), .MEM_SIGN(a_mem_sign), .MEM_SIZE(a_mem_size),
        .MEM_DOUT2(MEM_DOUT2)
    );

    data_mem_port_arbiter #(.MEM_LATENCY(3), .TAG_W(4)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .ld_req(ld_req_b), .ld_addr(ld_addr), .ld_type(ld_type), .ld_tag(ld_tag),
        .ld_gnt(b_ld_gnt), .ld_resp_valid(b_ld_resp_valid), .ld_resp_data(b_ld_resp_data),
        .ld_resp_tag(b_ld_resp_tag), .ld_resp_err(b_ld_resp_err),
        .st_req(st_req_b), .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .st_tag(st_tag),
        .st_gnt(b_st_gnt), .mem_resp_valid(b_mem_resp_valid), .mem_resp(b_mem_resp),
        .st_resp_tag(b_st_resp_tag),
        .MEM_ADDR2(b_mem_addr), .MEM_READ2(b_mem_read), .MEM_WRITE(b_mem_write),
        .MEM_WRITE_DATA(b_mem_wdata), .MEM_SIGN(b_mem_sign), .MEM_SIZE(b_mem_size),
        .MEM_DOUT2(MEM_DOUT2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0b expected %0b", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        logic exp_st, exp_ld;
        RST = 1'b1; ld_req = 1'b0; st_req = 1'b0; ld_req_b = 1'b0; st_req_b = 1'b0;
        ld_addr = 32'd0; st_addr = 32'd0; st_data = 32'd0; MEM_DOUT2 = 32'd0;
        ld_type = 3'd0; st_type = 3'd0; ld_tag = 4'd0; st_tag = 4'd0;

        // Reset state
        smp();
        chk1("rst_st_gnt", a_st_gnt, 1'b0);
        chk1("rst_ld_gnt", a_ld_gnt, 1'b0);
        chk1("rst_write", a_mem_write, 1'b0);
        chk32("rst_addr", a_mem_addr, 32'd0);
        chk1("rst_mem_resp_valid", a_mem_resp_valid, 1'b0);
        adv(); adv();
        RST = 1'b0;
        adv();

        // Test 1: lone aligned store, latency 1
        st_req = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_type = 3'b010; st_tag = 4'd5;
        smp();
        chk1("t1_st_gnt_c0", a_st_gnt, 1'b1);
        chk1("t1_ld_gnt_c0", a_ld_gnt, 1'b0);
        chk1("t1_write_c0", a_mem_write, 1'b0);
        adv(); st_req = 1'b0;
        smp();
        chk1("t1_write_c1", a_mem_write, 1'b1);
        chk1("t1_read_c1", a_mem_read, 1'b0);
        chk32("t1_addr_c1", a_mem_addr, 32'h100);
        chk32("t1_wdata_c1", a_mem_wdata, 32'hDEADBEEF);
        chk1("t1_resp_valid_c1", a_mem_resp_valid, 1'b0);
        adv(); smp();
        chk1("t1_resp_valid_c2", a_mem_resp_valid, 1'b1);
        chk1("t1_mem_resp_c2", a_mem_resp, 1'b1);
        chk4("t1_tag_c2", a_st_resp_tag, 4'd5);
        chk1("t1_write_c2", a_mem_write, 1'b0);
        chk32("t1_addr_c2", a_mem_addr, 32'd0);
        adv(); smp();
        chk1("t1_resp_valid_c3", a_mem_resp_valid, 1'b0);
        adv();

        // Test 2: simultaneous requests after reset, store wins first
        RST = 1'b1; adv(); RST = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h40; ld_type = 3'b010; ld_tag = 4'd3;
        st_req = 1'b1; st_addr = 32'h80; st_type = 3'b010; st_tag = 4'd7; st_data = 32'h11112222;
        MEM_DOUT2 = 32'hA5A50001;
        smp();
        chk1("t2_st_gnt_c0", a_st_gnt, 1'b1);
        chk1("t2_ld_gnt_c0", a_ld_gnt, 1'b0);
        adv(); st_req = 1'b0;
        smp();
        chk1("t2_ld_gnt_access", a_ld_gnt, 1'b0);
        adv(); smp();
        chk1("t2_ld_gnt_resp", a_ld_gnt, 1'b0);
        chk1("t2_st_resp_valid", a_mem_resp_valid, 1'b1);
        chk4("t2_st_resp_tag", a_st_resp_tag, 4'd7);
        adv();
        st_req = 1'b1; st_addr = 32'h84; st_tag = 4'd8;
        smp();
        chk1("t2_ld_gnt_c3", a_ld_gnt, 1'b1);
        chk1("t2_st_gnt_c3", a_st_gnt, 1'b0);
        adv(); ld_req = 1'b0;
        smp();
        chk1("t2_read_c4", a_mem_read, 1'b1);
        chk32("t2_addr_c4", a_mem_addr, 32'h40);
        chk1("t2_st_gnt_c4", a_st_gnt, 1'b0);
        adv(); smp();
        chk1("t2_ld_resp_valid_c5", a_ld_resp_valid, 1'b1);
        chk32("t2_ld_resp_data_c5", a_ld_resp_data, 32'hA5A50001);
        chk4("t2_ld_resp_tag_c5", a_ld_resp_tag, 4'd3);
        chk1("t2_st_gnt_c5", a_st_gnt, 1'b0);
        adv(); smp();
        chk1("t2_st_gnt_c6", a_st_gnt, 1'b1);
        adv(); st_req = 1'b0;
        smp();
        chk1("t2_write_c7", a_mem_write, 1'b1);
        chk32("t2_addr_c7", a_mem_addr, 32'h84);
        adv(); smp();
        chk1("t2_st_resp_valid_c8", a_mem_resp_valid, 1'b1);
        chk4("t2_st_resp_tag_c8", a_st_resp_tag, 4'd8);
        adv();

        // Test 3: load on latency-3 instance
        ld_req_b = 1'b1; ld_addr = 32'h200; ld_type = 3'b010; ld_tag = 4'd9; MEM_DOUT2 = 32'h12345678;
        smp();
        chk1("t3_gnt_c0", b_ld_gnt, 1'b1);
        adv(); ld_req_b = 1'b0;
        smp();
        chk1("t3_read_c1", b_mem_read, 1'b1);
        chk32("t3_addr_c1", b_mem_addr, 32'h200);
        adv(); smp();
        chk1("t3_read_c2", b_mem_read, 1'b0);
        chk32("t3_addr_c2", b_mem_addr, 32'h200);
        adv(); smp();
        chk1("t3_valid_c3", b_ld_resp_valid, 1'b0);
        chk32("t3_addr_c3", b_mem_addr, 32'h200);
        adv(); smp();
        chk1("t3_valid_c4", b_ld_resp_valid, 1'b1);
        chk32("t3_data_c4", b_ld_resp_data, 32'h12345678);
        chk4("t3_tag_c4", b_ld_resp_tag, 4'd9);
        chk32("t3_addr_c4", b_mem_addr, 32'd0);
        adv(); smp();
        chk1("t3_valid_c5", b_ld_resp_valid, 1'b0);
        adv();

        // Test 4: misaligned store, misaligned half load, aligned unsigned byte load
        st_req = 1'b1; st_addr = 32'h102; st_type = 3'b010; st_tag = 4'hA; MEM_DOUT2 = 32'hFFFF0000;
        smp();
        chk1("t4_st_gnt", a_st_gnt, 1'b1);
        adv(); st_req = 1'b0;
        smp();
        chk1("t4_write_c1", a_mem_write, 1'b0);
        chk1("t4_resp_valid_c1", a_mem_resp_valid, 1'b1);
        chk1("t4_mem_resp_c1", a_mem_resp, 1'b0);
        chk4("t4_tag_c1", a_st_resp_tag, 4'hA);
        adv(); smp();
        chk1("t4_write_c2", a_mem_write, 1'b0);
        chk1("t4_resp_valid_c2", a_mem_resp_valid, 1'b0);
        adv();
        ld_req = 1'b1; ld_addr = 32'h201; ld_type = 3'b001; ld_tag = 4'hC;
        smp();
        chk1("t4_ld_gnt", a_ld_gnt, 1'b1);
        adv(); ld_req = 1'b0;
        smp();
        chk1("t4_ld_valid", a_ld_resp_valid, 1'b1);
        chk1("t4_ld_err", a_ld_resp_err, 1'b1);
        chk32("t4_ld_data", a_ld_resp_data, 32'd0);
        chk4("t4_ld_tag", a_ld_resp_tag, 4'hC);
        chk1("t4_ld_read", a_mem_read, 1'b0);
        adv(); adv();
        ld_req = 1'b1; ld_addr = 32'h203; ld_type = 3'b100; ld_tag = 4'h1;
        smp();
        chk1("t4b_ld_gnt", a_ld_gnt, 1'b1);
        adv(); ld_req = 1'b0;
        smp();
        chk1("t4b_read", a_mem_read, 1'b1);
        chk1("t4b_sign", a_mem_sign, 1'b1);
        chk32("t4b_size", {30'd0, a_mem_size}, 32'd0);
        adv(); smp();
        chk1("t4b_valid", a_ld_resp_valid, 1'b1);
        chk1("t4b_err", a_ld_resp_err, 1'b0);
        chk32("t4b_data", a_ld_resp_data, 32'hFFFF0000);
        adv(); adv();

        // Test 5: reset during a load access
        ld_req = 1'b1; ld_addr = 32'h300; ld_type = 3'b010; ld_tag = 4'd2;
        smp();
        chk1("t5_gnt", a_ld_gnt, 1'b1);
        adv(); ld_req = 1'b0;
        #1;
        chk1("t5_read_pre", a_mem_read, 1'b1);
        RST = 1'b1;
        #1;
        chk1("t5_read_rst", a_mem_read, 1'b0);
        chk32("t5_addr_rst", a_mem_addr, 32'd0);
        adv(); RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk1("t5_no_resp", a_ld_resp_valid, 1'b0);
            adv();
        end
        ld_req = 1'b1; ld_addr = 32'h304; ld_tag = 4'd6;
        smp();
        chk1("t5_regnt", a_ld_gnt, 1'b1);
        adv(); ld_req = 1'b0;
        smp();
        chk1("t5_reread", a_mem_read, 1'b1);
        chk32("t5_readdr", a_mem_addr, 32'h304);
        adv(); smp();
        chk1("t5_revalid", a_ld_resp_valid, 1'b1);
        chk4("t5_retag", a_ld_resp_tag, 4'd6);
        adv();

        // Test 6: continuous dual requests, last grant was a load so store leads
        ld_req = 1'b1; st_req = 1'b1; ld_addr = 32'h400; st_addr = 32'h500;
        ld_type = 3'b010; st_type = 3'b010;
        for (int i = 0; i < 20; i++) begin
            exp_st = ((i % 3) == 0) && (((i / 3) % 2) == 0);
            exp_ld = ((i % 3) == 0) && (((i / 3) % 2) == 1);
            smp();
            chk1("t6_st_gnt", a_st_gnt, exp_st);
            chk1("t6_ld_gnt", a_ld_gnt, exp_ld);
            chk1("t6_two_gnt", a_st_gnt & a_ld_gnt, 1'b0);
            adv();
        end
        ld_req = 1'b0; st_req = 1'b0;
        adv(); adv(); adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
